// File: rtl/vram_pkg.sv
// Shared types for the video RAM port arbiter: FSM states and read owner tags.
package vram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CPU_WAIT = 2'd2,
        ST_CPU_DONE = 2'd3
    } state_e;

    // Owner of the read issued last cycle; decides where ram_q is routed.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

endpackage

// File: rtl/vram_clear_seq.sv
// Post-reset zero-fill address walker. The counter only moves on cycles the
// arbiter grants a clear write; done flags the final word's write cycle.
module vram_clear_seq #(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              restart,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next address: hold at zero while restarting, step on granted writes.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr = cnt_q;
    assign done = advance && (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/vram_port_mux.sv
// Single-port video RAM arbiter: video reads always win, then the post-reset
// clear, then the CPU. One access issues per cycle; a one-cycle owner tag
// routes the registered RAM read data back to its requester.
module vram_port_mux
    import vram_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_e            state_q, state_d;
    tag_e              tag_q, tag_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;

    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              wren_c;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_adv, clr_done, clr_restart;

    // Counter sits at zero whenever no clear is running.
    assign clr_restart = (state_q != ST_CLEAR);

    vram_clear_seq #(.ADDR_W(ADDR_W)) u_clear (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (clr_adv),
        .restart (clr_restart),
        .addr    (clr_addr),
        .done    (clr_done)
    );

    // Issue mux and FSM: video first, then clear write, then the CPU access.
    always_comb begin
        state_d     = state_q;
        tag_d       = TAG_NONE;
        addr_c      = '0;
        data_c      = '0;
        wren_c      = 1'b0;
        clr_adv     = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        if (vid_req) begin
            addr_c = vid_addr;
            tag_d  = TAG_VID;
        end

        case (state_q)
            ST_CLEAR: begin
                if (!vid_req) begin
                    addr_c  = clr_addr;
                    wren_c  = 1'b1;
                    clr_adv = 1'b1;
                    if (clr_done) state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cpu_req && !vid_req) begin
                    addr_c = cpu_addr;
                    if (cpu_we) begin
                        wren_c  = 1'b1;
                        data_c  = cpu_wdata;
                        state_d = ST_CPU_DONE;
                    end else begin
                        tag_d   = TAG_CPU;
                        state_d = ST_CPU_WAIT;
                    end
                end
            end
            ST_CPU_WAIT: begin
                // A video read issued now carries its own tag, so capture is safe.
                if (tag_q == TAG_CPU) cpu_rdata_d = ram_q;
                state_d = ST_CPU_DONE;
            end
            // Ack cycle: no new CPU issue while the requester drops cpu_req.
            ST_CPU_DONE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Only reached from an IDLE write or from CPU_WAIT, so this is a pulse.
        cpu_ack_d   = (state_d == ST_CPU_DONE);
        vid_valid_d = (tag_q == TAG_VID);
        vid_data_d  = vid_valid_d ? ram_q : vid_data_q;
    end

    // State, tag pipeline and registered results; reset drops any CPU access.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            tag_q       <= TAG_NONE;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    // Writes are suppressed while reset is held so no stale access lands.
    assign ram_wren    = wren_c & reset_n;
    assign ram_address = addr_c;
    assign ram_data    = data_c;
    assign busy        = (state_q == ST_CLEAR);
    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;

endmodule
